// File: rtl/bit_unpacker_d2.sv
// Bitstream unpacker: buffers LSB-first input chunks and extracts variable-length
// fields on request, zero-extended to I_WIDTH, through a one-deep output register.
module bit_unpacker_d2 #(
  parameter int unsigned WIDTH     = 196,
  parameter int unsigned I_WIDTH   = 128,
  parameter int unsigned SHIFT_BIT = 7,
  parameter int unsigned IN_W      = 64,
  localparam int unsigned LW       = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_flush,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [IN_W-1:0]      i_in_data,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_comp_flag,
  input  logic [SHIFT_BIT-1:0] i_req_len,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [I_WIDTH-1:0]   o_out_word,
  output logic [LW-1:0]        o_level
);

  localparam int unsigned CW = LW + 1;

  logic [WIDTH-1:0]     bits_q, bits_d;
  logic [LW-1:0]        cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [I_WIDTH-1:0]   out_word_q, out_word_d;

  logic [SHIFT_BIT-1:0] len_eff;
  logic [SHIFT_BIT-1:0] consume;
  logic [CW-1:0]        cnt_w;
  logic [LW-1:0]        wr_pos;
  logic [I_WIDTH-1:0]   ones;
  logic [I_WIDTH-1:0]   mask;
  logic                 in_ready;
  logic                 req_ready;
  logic                 out_free;
  logic                 in_fire;
  logic                 req_fire;

  // Handshake decode; input readiness looks only at registered occupancy.
  always_comb begin
    len_eff   = i_req_comp_flag ? i_req_len : '0;
    cnt_w     = CW'(cnt_q);
    in_ready  = (cnt_w + CW'(IN_W)) <= CW'(WIDTH);
    out_free  = !out_valid_q || i_out_ready;
    req_ready = out_free && (cnt_w >= CW'(len_eff));
    in_fire   = i_in_valid && in_ready;
    req_fire  = i_req_valid && req_ready;
    consume   = req_fire ? len_eff : '0;
    wr_pos    = cnt_q - LW'(consume);
    ones      = '1;
    mask      = ~(ones << len_eff);
  end

  // A new chunk lands just above the bits that survive this cycle's consume.
  always_comb begin
    bits_d      = bits_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    if (i_flush) begin
      bits_d      = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      out_word_d  = '0;
    end else begin
      bits_d = bits_q >> consume;
      if (in_fire) begin
        bits_d = bits_d | (WIDTH'(i_in_data) << wr_pos);
      end
      cnt_d = cnt_q - LW'(consume) + (in_fire ? LW'(IN_W) : LW'(0));
      if (req_fire) begin
        out_valid_d = 1'b1;
        out_word_d  = bits_q[I_WIDTH-1:0] & mask;
      end else if (i_out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else begin
      bits_q      <= bits_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
    end
  end

  assign o_in_ready  = in_ready;
  assign o_req_ready = req_ready;
  assign o_out_valid = out_valid_q;
  assign o_out_word  = out_word_q;
  assign o_level     = cnt_q;

endmodule
